// File: rtl/bit_shifter_pkg.sv
// Shared widths and helpers for the chip-select delay stage.
package bit_shifter_pkg;

  localparam int LEN_W     = 4;
  localparam int MAX_DELAY = 15;
  localparam int SR_W      = MAX_DELAY;

  typedef logic [LEN_W-1:0] len_t;

  // Delay selection wraps 15 -> 0 through natural 4-bit overflow.
  function automatic len_t len_next(input len_t l);
    return l + len_t'(1);
  endfunction

endpackage

// File: rtl/bit_shifter_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, sample prescaler,
// N-consecutive-sample level filter and a single press pulse per 0->1 change.
module btn_debounce #(
  parameter int DIV = 16,
  parameter int N   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic sample_en,
  output logic press
);

  localparam int PW = $clog2(DIV);
  localparam int MW = $clog2(N + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(N - 1);

  logic [1:0]    sync_q;
  logic [PW-1:0] pre_cnt;
  logic [MW-1:0] match_cnt;
  logic          level;

  assign sample_en = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      pre_cnt   <= '0;
      match_cnt <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      press   <= 1'b0;
      pre_cnt <= sample_en ? '0 : pre_cnt + PW'(1);
      if (sample_en) begin
        if (sync_q[1] != level) begin
          // The Nth differing sample flips the level; press only on a rise.
          if (match_cnt == MATCH_LAST) begin
            level     <= ~level;
            match_cnt <= '0;
            press     <= ~level;
          end else begin
            match_cnt <= match_cnt + MW'(1);
          end
        end else begin
          match_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/bit_shifter.sv
// SPI chip-select delay stage: CS is retimed by len (0..15) clocks,
// SCK and MISO pass straight through; a button press steps len.
module bit_shifter
  import bit_shifter_pkg::*;
#(
  parameter int DIV = 16,
  parameter int N   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sdo,
  input  logic btn_raw,
  output logic miso,
  output logic o_clk,
  output logic o_cs,
  output logic o_cs_en
);

  logic            rst_meta;
  logic            rst_int;
  logic            sample_en;
  logic            inc;
  len_t            len;
  logic [SR_W-1:0] sr;
  logic [SR_W:0]   taps;

  // Asserts immediately, releases two edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  btn_debounce #(
    .DIV (DIV),
    .N   (N)
  ) u_btn (
    .clk       (clk),
    .rst       (rst_int),
    .btn_raw   (btn_raw),
    .sample_en (sample_en),
    .press     (inc)
  );

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      len <= '0;
      sr  <= '0;
    end else begin
      sr <= {sr[SR_W-2:0], cs};
      if (inc) len <= len_next(len);
    end
  end

  // Tap 0 is the live input, so len=0 is a zero-latency path.
  assign taps    = {sr, cs};
  assign o_cs    = taps[len];
  assign o_cs_en = (len != '0);
  assign miso    = sdo;
  assign o_clk   = clk;

  // A press pulse always lands in the cycle after a sample strobe.
  a_press_after_sample : assert property (@(posedge clk) disable iff (rst_int) inc |-> !sample_en);

endmodule

// File: tb/tb_bit_shifter.sv
// Directed bench for bit_shifter: CS pulses are scoreboarded by arrival cycle,
// button sequences and reset behaviour are checked against a small len model.
module tb_bit_shifter;

  localparam int DIV = 16;
  localparam int N   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b0;
  logic sdo = 1'b0;
  logic btn_raw = 1'b0;
  logic miso, o_clk, o_cs, o_cs_en;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int exp_len = 0;
  int exp_q[$];

  bit_shifter #(.DIV(DIV), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .sdo     (sdo),
    .btn_raw (btn_raw),
    .miso    (miso),
    .o_clk   (o_clk),
    .o_cs    (o_cs),
    .o_cs_en (o_cs_en)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #3;
    sdo = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every delayed CS rising edge pops the expected arrival cycle.
  logic prev_cs = 1'b0;
  logic in_pulse = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    chk("miso_pass", int'(miso), int'(sdo));
    chk("o_clk_fwd", int'(o_clk), int'(clk));
    if (o_cs_en && o_cs && !prev_cs) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_pulse: o_cs rose at cycle %0d with no pulse expected", cyc);
      end else begin
        chk("pulse_time", cyc, exp_q.pop_front());
      end
      rise_cyc = cyc;
      in_pulse = 1'b1;
    end else if (in_pulse && !o_cs) begin
      chk("pulse_width", cyc - rise_cyc, 1);
      in_pulse = 1'b0;
    end
    prev_cs = o_cs_en & o_cs;
  end

  task automatic wait_samples(input int n);
    int got = 0;
    for (int i = 0; i < n * DIV * 2 + 4 && got < n; i++) begin
      @(negedge clk);
      if (dut.sample_en) got++;
    end
    chk("sample_en_wait", got, n);
  endtask

  task automatic press();
    @(posedge clk); #2 btn_raw = 1'b1;
    wait_samples(5);
    @(posedge clk); #2 btn_raw = 1'b0;
    wait_samples(5);
    exp_len = (exp_len + 1) % 16;
    chk("len_after_press", int'(dut.len), exp_len);
  endtask

  task automatic pulse_cs(input int k);
    int c0;
    @(posedge clk); #2;
    c0 = cyc;
    exp_q.push_back(c0 + k);
    cs = 1'b1;
    @(posedge clk); #2 cs = 1'b0;
    repeat (k + 3) @(posedge clk);
    #1 chk("pulse_drained", exp_q.size(), 0);
  endtask

  task automatic comb_follow(input string tag);
    @(posedge clk); #2 cs = 1'b1;
    #1 chk({tag, "_cs_hi"}, int'(o_cs), 1);
    cs = 1'b0;
    #1 chk({tag, "_cs_lo"}, int'(o_cs), 0);
    cs = 1'b1;
    #1 chk({tag, "_cs_hi2"}, int'(o_cs), 1);
    cs = 1'b0;
    chk({tag, "_en"}, int'(o_cs_en), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_len", int'(dut.len), 0);
    chk("rst_sr", int'(dut.sr), 0);
    chk("rst_en", int'(o_cs_en), 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (10) @(posedge clk);

    wait_samples(1);
    t1 = cyc;
    wait_samples(1);
    chk("sample_period", cyc - t1, DIV);

    comb_follow("len0");

    // Chattered press
    repeat (8) begin
      @(posedge clk); #2 btn_raw = ~btn_raw;
    end
    @(posedge clk); #2 btn_raw = 1'b1;
    wait_samples(4);
    repeat (6) begin
      @(posedge clk); #2 btn_raw = ~btn_raw;
    end
    @(posedge clk); #2 btn_raw = 1'b0;
    wait_samples(3);
    exp_len = 1;
    chk("chatter_len", int'(dut.len), exp_len);
    chk("chatter_en", int'(o_cs_en), 1);
    wait_samples(4);
    chk("chatter_settled", int'(dut.len), exp_len);

    // Long press, no auto-repeat
    @(posedge clk); #2 btn_raw = 1'b1;
    wait_samples(10);
    exp_len = exp_len + 1;
    chk("long_hold_len", int'(dut.len), exp_len);
    @(posedge clk); #2 btn_raw = 1'b0;
    wait_samples(4);
    chk("long_release_len", int'(dut.len), exp_len);
    wait_samples(3);

    chk("len_is_2", int'(dut.len), 2);
    pulse_cs(2);
    repeat (3) press();
    chk("len_is_5", int'(dut.len), 5);
    pulse_cs(5);

    // Reset with a pulse in flight at len=5
    @(posedge clk); #2 cs = 1'b1;
    @(posedge clk); #2 cs = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_len", int'(dut.len), 0);
    chk("midrst_sr", int'(dut.sr), 0);
    chk("midrst_en", int'(o_cs_en), 0);
    cs = 1'b1;
    #1 chk("midrst_cs_follow", int'(o_cs), 1);
    cs = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    exp_len = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_len", int'(dut.len), 0);
    chk("postrst_sr", int'(dut.sr), 0);

    // Wrap through 15 back to 0
    repeat (15) press();
    chk("len_is_15", int'(dut.len), 15);
    pulse_cs(15);
    press();
    chk("wrap_len", int'(dut.len), 0);
    comb_follow("wrap");

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bit_shifter.md
Name: bit_shifter

Overview:
- SPI chip-select delay stage with a pushbutton-selectable delay.
- o_cs reproduces cs delayed by len clock cycles; len is 0..15.
- Each debounced press of btn_raw increments len, wrapping 15 -> 0.
- Sits between the SPI master and the slave: clock and data lines pass straight through, only CS is retimed.

Parameters:
- DIV, 16, sampling prefix: one debounce sample every DIV clk cycles (DIV >= 2).
- N, 3, consecutive identical samples required to accept a new button level (N >= 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- cs  input  1  chip select from master.
- sdo  input  1  serial data from slave.
- btn_raw  input  1  raw, asynchronous, bouncing pushbutton, active-high.
- miso  output  1  equals sdo (combinational pass-through).
- o_clk  output  1  equals clk (forwarded).
- o_cs  output  1  delayed chip select.
- o_cs_en  output  1  high when len != 0 (delay path active).

Behaviour:
- Reset:
  - rst asserts asynchronously.
  - Internal reset is released synchronously through a 2-flop stretcher, so logic leaves reset 2 clk edges after rst falls.
  - In reset: len=0, delay shift register all 0, prescaler=0, sample counter=0, debounced level=0, synchronizer flops=0.
  - Output values in reset: o_cs=cs (len=0 path), o_cs_en=0.
- Button synchronizer: btn_raw passes through a 2-flop synchronizer before any use.
- Prescaler:
  - Counts 0..DIV-1.
  - Internal strobe sample_en is a 1-cycle pulse when the count equals DIV-1, i.e. once every DIV cycles.
  - sample_en and len keep those exact internal names, for bench probing.
- Debounce:
  - On each sample_en, compare the synchronized button with the current debounced level.
  - If different, increment the match counter; if equal, clear it.
  - When the counter reaches N, the debounced level toggles and the counter clears.
  - Bounce shorter than one sample period, or any run of fewer than N consecutive differing samples, has no effect.
- Press detect:
  - A 0->1 transition of the debounced level produces a 1-cycle inc pulse.
  - Release (1->0) does nothing.
  - Holding the button never auto-repeats.
- len:
  - 4-bit register; len <= len+1 mod 16 on inc, so 15 -> 0.
  - Updated one cycle after the debounced level rises.
- Delay line:
  - 15-bit shift register sr, shifts every clk: sr <= {sr[13:0], cs}.
  - len=0: o_cs = cs combinationally, zero latency.
  - len=k (1..15): o_cs = sr[k-1], so o_cs in cycle t equals cs as sampled at the edge k cycles earlier. A 1-cycle cs pulse emerges as a 1-cycle o_cs pulse exactly k cycles later.
- Changing len mid-stream: o_cs switches immediately to the new tap. Glitches or dropped/duplicated CS edges are acceptable at that moment; the shift register is not flushed.
- Width rules: prescaler width clog2(DIV); match counter width clog2(N+1); no saturation needed beyond wrap of len.
- Reset mid-operation: everything returns to the reset values, including len=0.

Decomposition:
- Shared package bit_shifter_pkg: LEN_W=4, MAX_DELAY=15, delay-register width MAX_DELAY.
- One natural sub-module: btn_debounce.
  - Contents: synchronizer, prescaler, N-sample filter, rising-edge pulse.
  - Outputs: sample_en and a 1-cycle press pulse.
- The delay line and len counter stay in bit_shifter.

Test Plan:
All tests use DIV=16, N=3, clk 50 MHz.
- Reset then len=0 path: after rst and 10 cycles, toggle cs 0->1->0 with no clock edge -> o_cs equals cs within 1 ns each time; o_cs_en=0.
- Chattered press:
  - Stimulus: 8 single-cycle toggles of btn_raw, then hold 1 for 4 sample_en, then 6 toggles, then hold 0 for 3 sample_en.
  - Response: len goes 0 -> 1 exactly once; o_cs_en=1.
- Long press: hold btn_raw=1 for 10 sample_en, release for 4 -> len increases by exactly 1, no repeat.
- Delay accuracy:
  - Set len=2, drive a 1-cycle cs pulse -> o_cs high for exactly one cycle, 2 cycles after the capture edge, low on the next cycle.
  - Repeat with len=5 -> 5 cycles.
- Wrap: press until len=15, press once more -> len=0 and o_cs again follows cs combinationally.
- Async reset mid-delay: with len=5 and a pulse in flight, assert rst -> len=0, sr cleared, no delayed pulse appears after release; miso tracks sdo throughout.
